xor_stream_descrambler: RTL and testbench
=========================================

// Module: xor_stream_descrambler
// PURPOSE
//  Receive end of the 5-bit XOR scrambling link: recovers plain words by XORing each received
//  5-bit word with a keystream from a 5-bit maximal-length LFSR (x^5+x^3+1, period 31).
//  Sits behind the link input and in front of the consumer.
//  Valid/ready on both sides; 1-cycle registered output; seed (re)sync input aligns the
//  keystream with the transmit-side scrambler.
// PARAMETERS
//  DATA_W        5        word width; LFSR width equals DATA_W, and only 5 is legal
//  CNT_W         8        width of accepted-word counter
//  RESET_SEED    5'b00001 LFSR value loaded at reset
// PORTS
//  clk          in   1       system clock, rising edge
//  reset        in   1       synchronous, active-high
//  sync_load    in   1       load sync_seed into LFSR, enter RUN, flush output register
//  sync_seed    in   DATA_W  seed value sampled when sync_load=1
//  in_valid     in   1       scrambled word present
//  in_data      in   DATA_W  scrambled word
//  in_ready     out  1       block accepts in_data this cycle
//  out_valid    out  1       descrambled word present
//  out_data     out  DATA_W  descrambled word
//  out_wrap     out  1       out_data was produced with keystream == last loaded seed (period start)
//  out_ready    in   1       consumer accepts out_data this cycle
//  word_count   out  CNT_W   number of accepted input words since last sync/reset, wraps
// BEHAVIOUR
//  - Reset: state=IDLE, lfsr=RESET_SEED, seed_reg=RESET_SEED, out_valid=0, out_data=0, out_wrap=0, word_count=0.
//  - States: IDLE (unsynced, in_ready=0) -> RUN on sync_load. RUN -> RUN on sync_load (resync).
//    Only reset returns the block to IDLE.
//  - in_ready = (state==RUN) && !sync_load && (!out_valid || out_ready).
//  - Accept (in_valid && in_ready): out_data<=in_data^lfsr; out_wrap<=(lfsr==seed_reg); out_valid<=1;
//    lfsr<=next(lfsr); word_count<=word_count+1 (mod 2^CNT_W).
//  - next(s) = {s[3:0], s[4]^s[2]}; Fibonacci shift left; keystream word = current state.
//  - Output: out_valid held, out_data/out_wrap stable, until out_ready; out_valid clears when
//    out_ready=1 and no new accept. Accept and drain in the same cycle gives back-to-back
//    words at 1 word/cycle.
//  - Latency: accepted word appears on out_data on the next cycle; throughput 1 word/cycle.
//  - sync_load (highest priority after reset): lfsr<=sync_seed, seed_reg<=sync_seed,
//    out_valid<=0 (pending word discarded), word_count<=0, state<=RUN; in_data not accepted.
//  - Zero seed is illegal (LFSR lock-up): sync_seed==0 loads 5'b00001 into both lfsr and seed_reg.
//  - lfsr never reaches 0; after 31 accepts lfsr==seed_reg again and out_wrap marks that word.
//  - Reset mid-stream: pending output dropped, block returns to IDLE and needs a new sync_load.
//  - out_ready is ignored when out_valid=0; in_data is ignored when in_ready=0.
// STRUCTURE
//  - Shared package: DATA_W constant, LFSR tap constants (4,2), state enum {IDLE, RUN},
//    LFSR_ZERO_FIX = 5'b00001.
//  - One sub-module, xor_lfsr5_next: combinational next-state function, shared with the
//    transmit-side scrambler.
//  - Top: state register, lfsr/seed_reg registers, 1-entry output register, counter.
// TESTING
//  1. reset; in_valid=1 with no sync_load for 3 cycles -> in_ready=0, out_valid=0, word_count=0.
//  2. sync_load seed=00001; then send 00000,11111,11000,10000 with out_ready=1
//     -> out_data 00001,11101,11100,11001 on consecutive cycles; out_wrap=1 on the first word only.
//  3. Back-pressure: out_ready=0 after first word -> in_ready=0, out_data held at 00001;
//     release out_ready -> no word lost or duplicated, order preserved.
//  4. Send 32 words of 00000 after seed 00001 -> out_wrap=1 on words 1 and 32; word_count=32.
//  5. sync_load in the same cycle as in_valid, with a pending output -> that input is not
//     accepted, out_valid=0 next cycle, word_count=0.
//     sync_seed=00000 -> first output for input 00000 is 00001.
//  6. reset asserted mid-stream -> next cycle state=IDLE, out_valid=0, lfsr=RESET_SEED;
//     255 then 256 accepts -> word_count wraps to 0.

Source files
------------

// File: rtl/xor_stream_descrambler_pkg.sv
// Shared definitions for the 5-bit XOR scrambling link (receive and transmit ends).
// Word width, LFSR taps, control-state enum and the lock-up substitute seed.
package xor_stream_descrambler_pkg;

  localparam int DATA_W = 5;

  // Feedback taps for x^5 + x^3 + 1 in shift-left Fibonacci form
  localparam int TAP_A = 4;
  localparam int TAP_B = 2;

  localparam logic [DATA_W-1:0] LFSR_ZERO_FIX = 5'b00001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [DATA_W-1:0] legal_seed(input logic [DATA_W-1:0] seed);
    return (seed == '0) ? LFSR_ZERO_FIX : seed;
  endfunction

endpackage

// File: rtl/xor_stream_descrambler_lfsr.sv
// Combinational next-state of the 5-bit maximal-length LFSR (period 31).
// Shared between the scrambler and descrambler so both ends step identically.
module xor_lfsr5_next (
  input  logic [4:0] cur,
  output logic [4:0] nxt
);
  import xor_stream_descrambler_pkg::*;

  assign nxt = {cur[3:0], cur[TAP_A] ^ cur[TAP_B]};

endmodule

// File: rtl/xor_stream_descrambler.sv
// Receive-side descrambler: XORs each accepted word with the LFSR keystream and
// presents it through a 1-entry registered output with valid/ready handshaking.
module xor_stream_descrambler #(
  parameter int                DATA_W     = 5,
  parameter int                CNT_W      = 8,
  parameter logic [DATA_W-1:0] RESET_SEED = 5'b00001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync_load,
  input  logic [DATA_W-1:0] sync_seed,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wrap,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_count
);
  import xor_stream_descrambler_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] lfsr;
  logic [DATA_W-1:0] lfsr_nxt;
  logic [DATA_W-1:0] seed_reg;
  logic [DATA_W-1:0] seed_fixed;
  logic              accept;

  xor_lfsr5_next u_lfsr_next (
    .cur (lfsr),
    .nxt (lfsr_nxt)
  );

  assign seed_fixed = legal_seed(sync_seed);

  // A pending word may be replaced only when it is drained in the same cycle
  assign in_ready = (state == RUN) && !sync_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sync_load) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr     <= RESET_SEED;
      seed_reg <= RESET_SEED;
    end else if (sync_load) begin
      lfsr     <= seed_fixed;
      seed_reg <= seed_fixed;
    end else if (accept) begin
      lfsr     <= lfsr_nxt;
    end
  end

  // Resync discards any pending word so stale keystream output never leaks out
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_wrap  <= 1'b0;
    end else if (sync_load) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ lfsr;
      out_wrap  <= (lfsr == seed_reg);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sync_load) begin
      word_count <= '0;
    end else if (accept) begin
      word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Randomized self-checking bench for xor_stream_descrambler against a keystream-table model.
// The model derives the keystream from the bit recurrence b[n+5] = b[n] ^ b[n+2].
module tb_xor_stream_descrambler;

  logic       clk = 1'b0;
  logic       reset;
  logic       sync_load;
  logic [4:0] sync_seed;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_wrap;
  logic       out_ready;
  logic [7:0] word_count;

  int total = 0;
  int bad   = 0;

  logic [4:0] ks [31];
  bit         m_run;
  int         m_k;
  int         m_count;
  bit         m_valid;
  logic [4:0] m_data;
  bit         m_wrap;

  always #5 clk = ~clk;

  xor_stream_descrambler dut (
    .clk        (clk),
    .reset      (reset),
    .sync_load  (sync_load),
    .sync_seed  (sync_seed),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_wrap   (out_wrap),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Keystream word k is the 5-bit window b[k..k+4] of the m-sequence started from the seed
  task automatic buildKeystream(input logic [4:0] seed);
    logic [4:0] s;
    bit         b [36];
    s = (seed == 5'd0) ? 5'd1 : seed;
    for (int i = 0; i < 5; i++) b[i] = s[4-i];
    for (int n = 0; n < 31; n++) b[n+5] = b[n] ^ b[n+2];
    for (int k = 0; k < 31; k++) ks[k] = {b[k], b[k+1], b[k+2], b[k+3], b[k+4]};
  endtask

  task automatic applyStimulus(input bit rst, input bit sl, input logic [4:0] seed,
                               input bit iv, input logic [4:0] id, input bit ordy);
    bit m_ready;
    reset     = rst;
    sync_load = sl;
    sync_seed = seed;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    m_ready = m_run && !sl && (!m_valid || ordy);
    if (!rst) checkOutput("in_ready", in_ready, m_ready);
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_valid = 0; m_data = 0; m_wrap = 0; m_count = 0; m_k = 0;
      buildKeystream(5'b00001);
    end else if (sl) begin
      buildKeystream(seed);
      m_run = 1; m_k = 0; m_valid = 0; m_count = 0;
    end else if (iv && m_ready) begin
      m_data  = id ^ ks[m_k];
      m_wrap  = (m_k == 0);
      m_k     = (m_k + 1) % 31;
      m_valid = 1;
      m_count = (m_count + 1) % 256;
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    checkOutput("out_valid", out_valid, m_valid);
    checkOutput("out_data", out_data, m_data);
    checkOutput("out_wrap", out_wrap, m_wrap);
    checkOutput("word_count", word_count, m_count);
  endtask

  initial begin
    logic [4:0] t2_in  [4];
    logic [4:0] t2_exp [4];
    t2_in  = '{5'b00000, 5'b11111, 5'b11000, 5'b10000};
    t2_exp = '{5'b00001, 5'b11101, 5'b11100, 5'b11001};
    m_run = 0; m_valid = 0; m_data = 0; m_wrap = 0; m_count = 0; m_k = 0;

    $display("[TB] reset and unsynced input");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 5'($urandom), 1);
      checkOutput("t1_in_ready", in_ready, 0);
      checkOutput("t1_count", word_count, 0);
    end

    $display("[TB] directed words after seed 00001");
    applyStimulus(0, 1, 5'b00001, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, t2_in[i], 1);
      checkOutput("t2_data", out_data, t2_exp[i]);
      checkOutput("t2_wrap", out_wrap, (i == 0));
    end

    $display("[TB] back-pressure");
    applyStimulus(0, 1, 5'b00001, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 5'b00000, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 5'($urandom), 0);
      checkOutput("t3_hold", out_data, 5'b00001);
      checkOutput("t3_in_ready", in_ready, 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 5'($urandom), 1);

    $display("[TB] full keystream period");
    applyStimulus(0, 1, 5'b00001, 0, 0, 1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 1, 5'b00000, 1);
      checkOutput("t4_wrap", out_wrap, (i == 0 || i == 31));
    end
    checkOutput("t4_count", word_count, 32);

    $display("[TB] resync with pending word and zero seed");
    applyStimulus(0, 0, 0, 1, 5'b01010, 0);
    applyStimulus(0, 1, 5'b00000, 1, 5'b10101, 0);
    checkOutput("t5_valid", out_valid, 0);
    checkOutput("t5_count", word_count, 0);
    applyStimulus(0, 0, 0, 1, 5'b00000, 1);
    checkOutput("t5_zero_seed", out_data, 5'b00001);

    $display("[TB] reset mid-stream and counter wrap");
    applyStimulus(0, 0, 0, 1, 5'b00111, 0);
    applyStimulus(1, 0, 0, 1, 5'b00111, 0);
    checkOutput("t6_valid", out_valid, 0);
    applyStimulus(0, 0, 0, 1, 5'b00111, 1);
    checkOutput("t6_idle", in_ready, 0);
    applyStimulus(0, 1, 5'($urandom), 0, 0, 1);
    for (int i = 0; i < 255; i++) applyStimulus(0, 0, 0, 1, 5'($urandom), 1);
    checkOutput("t6_count255", word_count, 255);
    applyStimulus(0, 0, 0, 1, 5'($urandom), 1);
    checkOutput("t6_wrap0", word_count, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 399) == 0), ($urandom_range(0, 63) == 0),
                    5'($urandom), ($urandom_range(0, 3) != 0), 5'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
